// File: rtl/clkdiv_phase_gen.sv
// clkdiv_phase_gen: parametrised clock divider / phase generator on hclkin.
// Ports: hclkin, resetn (async low), calib (phase slip), sync_in (board sync),
//        clkout, clkout_q (delayed by DIV_MODE/4), rise_en, fall_en,
//        phase (counter), locked. Macro CLKDIV_RESYNC_EN enables sync lock.
module clkdiv_phase_gen #(
    parameter int DIV_MODE      = 4,
    parameter int SYNC_PHASE    = 0,
    parameter int SYNC_LOCK_CNT = 3
) (
    input  logic                        hclkin,
    input  logic                        resetn,
    input  logic                        calib,
    input  logic                        sync_in,
    output logic                        clkout,
    output logic                        clkout_q,
    output logic                        rise_en,
    output logic                        fall_en,
    output logic [$clog2(DIV_MODE)-1:0] phase,
    output logic                        locked
);
    localparam int W  = $clog2(DIV_MODE);
    localparam int Q  = DIV_MODE / 4;
    localparam int HI = (DIV_MODE + 1) / 2;

    localparam logic [W-1:0] LAST  = W'(DIV_MODE - 1);
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W:0]   HI_V  = (W+1)'(HI);
    localparam logic [W:0]   DIV_V = (W+1)'(DIV_MODE);
    // Adding DIV_MODE-Q and folding once gives (cnt - Q) mod DIV_MODE.
    localparam logic [W:0]   QOFF  = (W+1)'(DIV_MODE - Q);

    logic [W-1:0] cnt;
    logic [W-1:0] nxt;
    logic [W-1:0] cnt_d;
    logic [W:0]   qsum;
    logic [W:0]   qwrap;
    logic         calib_d;
    logic         calib_rise;
    logic         locked_d;

    assign phase      = cnt;
    assign calib_rise = calib & ~calib_d;

    // Free-run / slip value: a calib rising edge holds the counter once.
    always_comb begin
        nxt = '0;
        if (calib_rise)
            nxt = cnt;
        else if (cnt == LAST)
            nxt = '0;
        else
            nxt = cnt + ONE;
    end

    always_comb begin
        qsum  = {1'b0, cnt_d} + QOFF;
        qwrap = qsum;
        if (qsum >= DIV_V)
            qwrap = qsum - DIV_V;
    end

`ifdef CLKDIV_RESYNC_EN
    localparam int GW = $clog2(2 * DIV_MODE);

    localparam logic [W-1:0]  SP       = W'(SYNC_PHASE);
    localparam logic [3:0]    LOCK_N   = 4'(SYNC_LOCK_CNT);
    localparam logic [GW-1:0] GAP_LAST = GW'(2 * DIV_MODE - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [3:0]    match_cnt;
    logic [3:0]    match_d;
    logic [3:0]    match_inc;
    logic [GW-1:0] gap;
    logic [GW-1:0] gap_d;
    logic          sync_s1;
    logic          sync_s2;
    logic          sync_s3;
    logic          sedge;

    assign sedge     = sync_s2 & ~sync_s3;
    assign match_inc = match_cnt + 4'd1;

    // A sedge reload overrides any calib slip carried in nxt.
    always_comb begin
        cnt_d   = nxt;
        state_d = state;
        match_d = match_cnt;
        gap_d   = gap;
        unique case (state)
            ST_HUNT: begin
                if (sedge) begin
                    cnt_d   = SP;
                    match_d = 4'd0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (sedge) begin
                    if (nxt == SP) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_d = ST_LOCKED;
                            gap_d   = '0;
                        end
                    end else begin
                        cnt_d   = SP;
                        match_d = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                gap_d = gap + GAP_ONE;
                if (sedge) begin
                    gap_d = '0;
                    if (nxt != SP) begin
                        cnt_d   = SP;
                        match_d = 4'd0;
                        state_d = ST_CHECK;
                    end
                end else if (gap == GAP_LAST) begin
                    // Reference lost: fall back to free-running.
                    gap_d   = '0;
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    assign locked_d = (state_d == ST_LOCKED);

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            sync_s1   <= 1'b0;
            sync_s2   <= 1'b0;
            sync_s3   <= 1'b0;
            state     <= ST_HUNT;
            match_cnt <= 4'd0;
            gap       <= '0;
        end else begin
            sync_s1   <= sync_in;
            sync_s2   <= sync_s1;
            sync_s3   <= sync_s2;
            state     <= state_d;
            match_cnt <= match_d;
            gap       <= gap_d;
        end
    end
`else
    logic unused_sync;

    assign unused_sync = sync_in;
    assign cnt_d       = nxt;
    assign locked_d    = 1'b1;
`endif

    // Outputs decode the value being loaded so they always agree with phase.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            cnt      <= LAST;
            clkout   <= 1'b0;
            clkout_q <= 1'b0;
            rise_en  <= 1'b0;
            fall_en  <= 1'b0;
            calib_d  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            clkout   <= ({1'b0, cnt_d} < HI_V);
            clkout_q <= (qwrap < HI_V);
            rise_en  <= (cnt_d == '0);
            fall_en  <= ({1'b0, cnt_d} == HI_V);
            calib_d  <= calib;
            locked   <= locked_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_phase_gen.sv
// tb_clkdiv_phase_gen: scoreboard bench for clkdiv_phase_gen.
// Runs DIV_MODE=4 (SYNC_PHASE=1) and DIV_MODE=5 instances side by side.
module tb_clkdiv_phase_gen;

`ifdef CLKDIV_RESYNC_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       calib;
    logic       sync_in;
    logic       co4, cq4, re4, fe4, lk4;
    logic [1:0] ph4;
    logic       co5, cq5, re5, fe5, lk5;
    logic [2:0] ph5;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0] v;
        logic       lk;
    } e4_t;

    e4_t        sb4[$];
    logic [6:0] sb5[$];

    clkdiv_phase_gen #(.DIV_MODE(4), .SYNC_PHASE(1), .SYNC_LOCK_CNT(3)) dut4 (
        .hclkin(clk), .resetn(resetn), .calib(calib), .sync_in(sync_in),
        .clkout(co4), .clkout_q(cq4), .rise_en(re4), .fall_en(fe4),
        .phase(ph4), .locked(lk4)
    );

    clkdiv_phase_gen #(.DIV_MODE(5)) dut5 (
        .hclkin(clk), .resetn(resetn), .calib(calib), .sync_in(sync_in),
        .clkout(co5), .clkout_q(cq5), .rise_en(re5), .fall_en(fe5),
        .phase(ph5), .locked(lk5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected DIV 4 outputs: clkout 1100, clkout_q 0110, fall at phase 2.
    function automatic logic [5:0] exp4(input int ph);
        logic [3:0] cp;
        logic [3:0] qp;
        cp = 4'b1100;
        qp = 4'b0110;
        return {2'(ph), cp[3-ph], qp[3-ph], ph == 0, ph == 2};
    endfunction

    // Expected DIV 5 outputs: high 3 low 2, clkout_q 01110, fall at phase 3.
    function automatic logic [6:0] exp5(input int ph);
        logic [4:0] cp;
        logic [4:0] qp;
        cp = 5'b11100;
        qp = 5'b01110;
        return {3'(ph), cp[4-ph], qp[4-ph], ph == 0, ph == 3};
    endfunction

    function automatic logic sync_pat(input int n);
        return (n >= 3) && (((n - 3) % 4) < 2);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        calib   = 1'b0;
        sync_in = 1'b0;
        resetn  = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ph4, co4, cq4, re4, fe4, lk4} !== {2'd3, 5'b0}) begin
            failures++;
            $display("FAIL reset4 got=%b exp=%b",
                     {ph4, co4, cq4, re4, fe4, lk4}, {2'd3, 5'b0});
        end
        checks++;
        if ({ph5, co5, cq5, re5, fe5, lk5} !== {3'd4, 5'b0}) begin
            failures++;
            $display("FAIL reset5 got=%b exp=%b",
                     {ph5, co5, cq5, re5, fe5, lk5}, {3'd4, 5'b0});
        end
    endtask

    task automatic test_free_run();
        e4_t e;
        do_reset();
        for (int j = 0; j < 16; j++)
            sb4.push_back('{v: exp4(j % 4), lk: !RS});
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            #1;
            e = sb4.pop_front();
            checks++;
            if ({ph4, co4, cq4, re4, fe4, lk4} !== {e.v, e.lk}) begin
                failures++;
                $display("FAIL free_run cyc=%0d got=%b exp=%b", j,
                         {ph4, co4, cq4, re4, fe4, lk4}, {e.v, e.lk});
            end
        end
    endtask

    task automatic test_div5();
        logic [6:0] e;
        do_reset();
        for (int j = 0; j < 15; j++)
            sb5.push_back(exp5(j % 5));
        for (int j = 1; j <= 15; j++) begin
            @(posedge clk);
            #1;
            e = sb5.pop_front();
            checks++;
            if ({ph5, co5, cq5, re5, fe5} !== e) begin
                failures++;
                $display("FAIL div5 cyc=%0d got=%b exp=%b", j,
                         {ph5, co5, cq5, re5, fe5}, e);
            end
        end
    endtask

    task automatic test_calib();
        e4_t e;
        int  ph;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ph4 !== 2'd2) begin
            failures++;
            $display("FAIL calib_start got=%0d exp=2", ph4);
        end
        foreach (sb4[i]) sb4.delete(i);
        sb4.push_back('{v: exp4(2), lk: !RS});
        sb4.push_back('{v: exp4(3), lk: !RS});
        sb4.push_back('{v: exp4(0), lk: !RS});
        sb4.push_back('{v: exp4(1), lk: !RS});
        calib = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            calib = 1'b0;
            e = sb4.pop_front();
            checks++;
            if ({ph4, co4, cq4, re4, fe4} !== e.v) begin
                failures++;
                $display("FAIL calib_pulse cyc=%0d got=%b exp=%b", j,
                         {ph4, co4, cq4, re4, fe4}, e.v);
            end
        end
        // Phase is 1 now; holding calib may only repeat it once.
        for (int j = 1; j <= 12; j++) begin
            ph = (1 + ((j > 1) ? j - 1 : 0)) % 4;
            sb4.push_back('{v: exp4(ph), lk: !RS});
        end
        calib = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            #1;
            if (j == 10)
                calib = 1'b0;
            e = sb4.pop_front();
            checks++;
            if ({ph4, co4, cq4, re4, fe4} !== e.v) begin
                failures++;
                $display("FAIL calib_held cyc=%0d got=%b exp=%b", j,
                         {ph4, co4, cq4, re4, fe4}, e.v);
            end
        end
    endtask

`ifdef CLKDIV_RESYNC_EN
    task automatic test_sync_lock();
        e4_t e;
        int  ph;
        do_reset();
        // Pin rises before edge 3, sedge loads phase 1 at edge 5,
        // matching edges follow at 9, 13, 17.
        for (int n = 1; n <= 28; n++) begin
            ph = (n < 5) ? n - 1 : (n - 4) % 4;
            sb4.push_back('{v: exp4(ph), lk: (n >= 17)});
        end
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            sync_in = sync_pat(n);
            @(posedge clk);
            #1;
            e = sb4.pop_front();
            checks++;
            if ({ph4, co4, cq4, re4, fe4, lk4} !== {e.v, e.lk}) begin
                failures++;
                $display("FAIL sync_lock cyc=%0d got=%b exp=%b", n,
                         {ph4, co4, cq4, re4, fe4, lk4}, {e.v, e.lk});
            end
        end
    endtask

    task automatic test_sync_loss();
        e4_t e;
        // Last sedge acts at edge 29; locked must drop at edge 37.
        for (int n = 29; n <= 44; n++)
            sb4.push_back('{v: exp4((n - 4) % 4), lk: (n <= 36)});
        for (int n = 29; n <= 44; n++) begin
            @(negedge clk);
            sync_in = 1'b0;
            @(posedge clk);
            #1;
            e = sb4.pop_front();
            checks++;
            if ({ph4, co4, cq4, re4, fe4, lk4} !== {e.v, e.lk}) begin
                failures++;
                $display("FAIL sync_loss cyc=%0d got=%b exp=%b", n,
                         {ph4, co4, cq4, re4, fe4, lk4}, {e.v, e.lk});
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
`ifdef CLKDIV_RESYNC_EN
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            sync_in = sync_pat(n);
            @(posedge clk);
        end
`else
        repeat (20) @(posedge clk);
`endif
        #1;
        checks++;
        if (lk4 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_locked got=%b exp=1", lk4);
        end
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({ph4, co4, cq4, re4, fe4, lk4} !== {2'd3, 5'b0}) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b",
                     {ph4, co4, cq4, re4, fe4, lk4}, {2'd3, 5'b0});
        end
        @(negedge clk);
        sync_in = 1'b0;
        resetn  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ph4, co4, re4} !== 4'b0011) begin
            failures++;
            $display("FAIL reset_release got=%b exp=0011", {ph4, co4, re4});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn  = 1'b1;
        calib   = 1'b0;
        sync_in = 1'b0;
        #2;
        resetn = 1'b0;
        test_reset();
        test_free_run();
        test_div5();
        test_calib();
`ifdef CLKDIV_RESYNC_EN
        test_sync_lock();
        test_sync_loss();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
